// File: rtl/itlb_maint_ctrl.sv
// itlb_maint_ctrl: arbitrates the ITLB lower/upper write ports between software TLBL/TLBH writes and an invalidate-all sweep.
// Optional ITLB_MAINT_PERF_EN adds a saturating flush_cnt output.
module itlb_maint_ctrl #(
  parameter int CONFIG_DW          = 32,
  parameter int CONFIG_ITLB_P_SETS = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_req,
  output logic                          flush_busy,
  output logic                          flush_done,
  output logic                          fetch_stall,
  input  logic                          sw_tlbl_we,
  input  logic [CONFIG_ITLB_P_SETS-1:0] sw_tlbl_idx,
  input  logic [CONFIG_DW-1:0]          sw_tlbl_dat,
  output logic                          sw_tlbl_ready,
  input  logic                          sw_tlbh_we,
  input  logic [CONFIG_ITLB_P_SETS-1:0] sw_tlbh_idx,
  input  logic [CONFIG_DW-1:0]          sw_tlbh_dat,
  output logic                          tlbl_we,
  output logic [CONFIG_ITLB_P_SETS-1:0] tlbl_idx,
  output logic [CONFIG_DW-1:0]          tlbl_nxt,
  output logic                          tlbh_we,
  output logic [CONFIG_ITLB_P_SETS-1:0] tlbh_idx,
  output logic [CONFIG_DW-1:0]          tlbh_nxt
`ifdef ITLB_MAINT_PERF_EN
  ,output logic [15:0]                  flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [CONFIG_ITLB_P_SETS-1:0]   cnt_q, cnt_d;
  logic                            pend_q, pend_d;
  logic                            buf_v_q, buf_v_d;
  logic [CONFIG_ITLB_P_SETS-1:0]   buf_idx_q, buf_idx_d;
  logic [CONFIG_DW-1:0]            buf_dat_q, buf_dat_d;
  logic                            buf_load;
  logic                            restart;

  assign sw_tlbl_ready = ~((state_q != IDLE) & buf_v_q);
  assign fetch_stall   = state_q != IDLE;
  assign flush_busy    = (state_q != IDLE) | pend_q;
  assign restart       = pend_q | flush_req;
  // A write coinciding with a flush request is ordered after the flush.
  assign buf_load      = (state_q == IDLE)  ? flush_req & sw_tlbl_we :
                         (state_q == SWEEP) ? sw_tlbl_we & sw_tlbl_ready : 1'b0;

  assign tlbh_we  = sw_tlbh_we;
  assign tlbh_idx = sw_tlbh_idx;
  assign tlbh_nxt = sw_tlbh_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      buf_v_q   <= 1'b0;
      buf_idx_q <= '0;
      buf_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      buf_v_q   <= buf_v_d;
      buf_idx_q <= buf_idx_d;
      buf_dat_q <= buf_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    buf_v_d    = buf_load | buf_v_q;
    buf_idx_d  = buf_load ? sw_tlbl_idx : buf_idx_q;
    buf_dat_d  = buf_load ? sw_tlbl_dat : buf_dat_q;
    tlbl_we    = 1'b0;
    tlbl_idx   = sw_tlbl_idx;
    tlbl_nxt   = sw_tlbl_dat;
    flush_done = 1'b0;
    case (state_q)
      IDLE: begin
        tlbl_we = sw_tlbl_we & ~flush_req;
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        tlbl_we  = 1'b1;
        tlbl_idx = cnt_q;
        tlbl_nxt = '0;
        cnt_d    = cnt_q + 1'b1;
        pend_d   = restart;
        if (&cnt_q) begin
          if (buf_v_d) begin
            state_d = DRAIN;
          end else begin
            flush_done = 1'b1;
            pend_d     = 1'b0;
            state_d    = restart ? SWEEP : IDLE;
          end
        end
      end
      DRAIN: begin
        tlbl_we    = 1'b1;
        tlbl_idx   = buf_idx_q;
        tlbl_nxt   = buf_dat_q;
        buf_v_d    = 1'b0;
        flush_done = 1'b1;
        pend_d     = 1'b0;
        cnt_d      = '0;
        state_d    = restart ? SWEEP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ITLB_MAINT_PERF_EN
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flush_cnt_q <= '0;
    else if (flush_done && flush_cnt_q != 16'hFFFF)
      flush_cnt_q <= flush_cnt_q + 1'b1;
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_itlb_maint_ctrl.sv
// tb_itlb_maint_ctrl: directed and randomized checks of itlb_maint_ctrl with P_SETS=3 against an array-level model.
module tb_itlb_maint_ctrl;
  localparam int DW = 32;
  localparam int P  = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_req, flush_busy, flush_done, fetch_stall;
  logic          sw_tlbl_we, sw_tlbl_ready, sw_tlbh_we;
  logic [P-1:0]  sw_tlbl_idx, sw_tlbh_idx;
  logic [DW-1:0] sw_tlbl_dat, sw_tlbh_dat;
  logic          tlbl_we, tlbh_we;
  logic [P-1:0]  tlbl_idx, tlbh_idx;
  logic [DW-1:0] tlbl_nxt, tlbh_nxt;
`ifdef ITLB_MAINT_PERF_EN
  logic [15:0]   flush_cnt;
`endif

  logic [DW-1:0] arr_l [N];
  logic [DW-1:0] arr_h [N];
  logic [DW-1:0] mod_l [N];
  logic [DW-1:0] mod_h [N];
  int            stall_n = 0;
  int            done_n  = 0;
  int            errors  = 0;
  int            checks  = 0;
  int            s0, d0, c, m, s;
  logic [34:0]   q[$];
  logic [34:0]   wr;
  logic [P-1:0]  hidx;
  logic [DW-1:0] hdat;

  always #5 clk = ~clk;

  itlb_maint_ctrl #(.CONFIG_DW(DW), .CONFIG_ITLB_P_SETS(P)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .fetch_stall(fetch_stall),
    .sw_tlbl_we(sw_tlbl_we), .sw_tlbl_idx(sw_tlbl_idx), .sw_tlbl_dat(sw_tlbl_dat),
    .sw_tlbl_ready(sw_tlbl_ready),
    .sw_tlbh_we(sw_tlbh_we), .sw_tlbh_idx(sw_tlbh_idx), .sw_tlbh_dat(sw_tlbh_dat),
    .tlbl_we(tlbl_we), .tlbl_idx(tlbl_idx), .tlbl_nxt(tlbl_nxt),
    .tlbh_we(tlbh_we), .tlbh_idx(tlbh_idx), .tlbh_nxt(tlbh_nxt)
`ifdef ITLB_MAINT_PERF_EN
    ,.flush_cnt(flush_cnt)
`endif
  );

  // Stand-in for the ITLB arrays plus event counters observed at the clock edge.
  always @(posedge clk) begin
    if (tlbl_we) arr_l[tlbl_idx] <= tlbl_nxt;
    if (tlbh_we) arr_h[tlbh_idx] <= tlbh_nxt;
    if (fetch_stall) stall_n <= stall_n + 1;
    if (flush_done) done_n <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    flush_req   = 1'b0;
    sw_tlbl_we  = 1'b0;
    sw_tlbl_idx = '0;
    sw_tlbl_dat = '0;
    sw_tlbh_we  = 1'b0;
    sw_tlbh_idx = '0;
    sw_tlbh_dat = '0;
  endtask

  task automatic clear_model_l();
    for (int k = 0; k < N; k++) mod_l[k] = '0;
  endtask

  task automatic cmp_arrays(input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_arr_l"}, 64'(arr_l[k]), 64'(mod_l[k]));
      chk({tag, "_arr_h"}, 64'(arr_h[k]), 64'(mod_h[k]));
    end
  endtask

  // One full sweep of N cycles; optionally raises flush_req at sweep cycle req_at.
  task automatic sweep(input int req_at, input logic last_done);
    for (int k = 0; k < N; k++) begin
      flush_req = (k == req_at);
      #1;
      chk("sweep_we", 64'(tlbl_we), 64'd1);
      chk("sweep_idx", 64'(tlbl_idx), 64'(k));
      chk("sweep_nxt", 64'(tlbl_nxt), 64'd0);
      chk("sweep_stall", 64'(fetch_stall), 64'd1);
      chk("sweep_busy", 64'(flush_busy), 64'd1);
      chk("sweep_done", 64'(flush_done), 64'((k == N - 1) & last_done));
      cyc();
    end
    flush_req = 1'b0;
  endtask

  initial begin
    idle_in();
    #1 rst = 1'b0;
    #2;
    chk("rst_tlbl_we", 64'(tlbl_we), 64'd0);
    chk("rst_ready", 64'(sw_tlbl_ready), 64'd1);
    chk("rst_busy", 64'(flush_busy), 64'd0);
    chk("rst_stall", 64'(fetch_stall), 64'd0);
    chk("rst_done", 64'(flush_done), 64'd0);
    chk("rst_tlbh_we", 64'(tlbh_we), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    for (int k = 0; k < N; k++) begin
      sw_tlbh_we = 1'b1; sw_tlbh_idx = P'(k); sw_tlbh_dat = '0; mod_h[k] = '0;
      #1;
      chk("h_init_we", 64'(tlbh_we), 64'd1);
      cyc();
    end
    idle_in();

    // Plain flush from idle
    flush_req = 1'b1;
    #1;
    chk("t1_req_we", 64'(tlbl_we), 64'd0);
    chk("t1_req_stall", 64'(fetch_stall), 64'd0);
    d0 = done_n;
    cyc();
    sweep(-1, 1'b1);
    #1;
    chk("t1_end_stall", 64'(fetch_stall), 64'd0);
    chk("t1_end_busy", 64'(flush_busy), 64'd0);
    chk("t1_done_pulses", 64'(done_n - d0), 64'd1);
    clear_model_l();
    cyc();

    // Idle pass-through
    sw_tlbl_we = 1'b1; sw_tlbl_idx = 3'd5; sw_tlbl_dat = 32'hABCD0001;
    #1;
    chk("t2_we", 64'(tlbl_we), 64'd1);
    chk("t2_idx", 64'(tlbl_idx), 64'd5);
    chk("t2_nxt", 64'(tlbl_nxt), 64'hABCD0001);
    chk("t2_ready", 64'(sw_tlbl_ready), 64'd1);
    cyc();
    idle_in();

    // Flush coinciding with a write: write drains after the sweep
    flush_req = 1'b1; sw_tlbl_we = 1'b1; sw_tlbl_idx = 3'd2; sw_tlbl_dat = 32'h1234_5678;
    #1;
    chk("t3_req_we", 64'(tlbl_we), 64'd0);
    chk("t3_req_ready", 64'(sw_tlbl_ready), 64'd1);
    cyc();
    idle_in();
    sweep(-1, 1'b0);
    #1;
    chk("t3_drain_we", 64'(tlbl_we), 64'd1);
    chk("t3_drain_idx", 64'(tlbl_idx), 64'd2);
    chk("t3_drain_nxt", 64'(tlbl_nxt), 64'h1234_5678);
    chk("t3_drain_done", 64'(flush_done), 64'd1);
    chk("t3_drain_stall", 64'(fetch_stall), 64'd1);
    cyc();
    #1;
    chk("t3_idle_stall", 64'(fetch_stall), 64'd0);
    chk("t3_arr2", 64'(arr_l[2]), 64'h1234_5678);
    cyc();

    // Back-to-back writes during a sweep, plus a TLBH write
    flush_req = 1'b1;
    #1;
    cyc();
    flush_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 2) begin sw_tlbl_we = 1'b1; sw_tlbl_idx = 3'd1; sw_tlbl_dat = 32'hAAAA_0001; end
      if (k == 3) begin
        sw_tlbl_idx = 3'd6; sw_tlbl_dat = 32'hBBBB_0006;
        sw_tlbh_we = 1'b1; sw_tlbh_idx = 3'd4; sw_tlbh_dat = 32'hCCCC_0004;
      end
      if (k == 4) sw_tlbh_we = 1'b0;
      #1;
      chk("t4_idx", 64'(tlbl_idx), 64'(k));
      chk("t4_ready", 64'(sw_tlbl_ready), 64'(k <= 2));
      if (k == 3) begin
        chk("t4_h_we", 64'(tlbh_we), 64'd1);
        chk("t4_h_idx", 64'(tlbh_idx), 64'd4);
        chk("t4_h_nxt", 64'(tlbh_nxt), 64'hCCCC_0004);
      end
      cyc();
    end
    #1;
    chk("t4_drain_idx", 64'(tlbl_idx), 64'd1);
    chk("t4_drain_nxt", 64'(tlbl_nxt), 64'hAAAA_0001);
    chk("t4_drain_ready", 64'(sw_tlbl_ready), 64'd0);
    chk("t4_drain_done", 64'(flush_done), 64'd1);
    cyc();
    #1;
    chk("t4_idle_ready", 64'(sw_tlbl_ready), 64'd1);
    chk("t4_idle_we", 64'(tlbl_we), 64'd1);
    chk("t4_idle_idx", 64'(tlbl_idx), 64'd6);
    chk("t4_idle_nxt", 64'(tlbl_nxt), 64'hBBBB_0006);
    cyc();
    idle_in();
    clear_model_l();
    mod_l[1] = 32'hAAAA_0001; mod_l[6] = 32'hBBBB_0006; mod_h[4] = 32'hCCCC_0004;
    #1;
    cmp_arrays("t4");
    cyc();

    // Flush requested mid-sweep restarts a second full sweep
    flush_req = 1'b1;
    #1;
    d0 = done_n;
    cyc();
    sweep(4, 1'b1);
    sweep(-1, 1'b1);
    #1;
    chk("t5_busy", 64'(flush_busy), 64'd0);
    chk("t5_stall", 64'(fetch_stall), 64'd0);
    chk("t5_done_pulses", 64'(done_n - d0), 64'd2);
    clear_model_l();
    cyc();

    // Randomized mix of idle writes and flushes with writes held until ready
    for (int it = 0; it < 25; it++) begin
      hidx = P'($urandom_range(0, N - 1));
      hdat = $urandom;
      sw_tlbh_we = 1'b1; sw_tlbh_idx = hidx; sw_tlbh_dat = hdat;
      mod_h[hidx] = hdat;
      if ($urandom_range(0, 1) == 0) begin
        sw_tlbl_we = 1'b1; sw_tlbl_idx = P'($urandom_range(0, N - 1)); sw_tlbl_dat = $urandom;
        #1;
        chk("rnd_w_we", 64'(tlbl_we), 64'd1);
        chk("rnd_w_idx", 64'(tlbl_idx), 64'(sw_tlbl_idx));
        chk("rnd_w_nxt", 64'(tlbl_nxt), 64'(sw_tlbl_dat));
        chk("rnd_h_nxt", 64'(tlbh_nxt), 64'(hdat));
        mod_l[sw_tlbl_idx] = sw_tlbl_dat;
        cyc();
        idle_in();
      end else begin
        c = $urandom_range(0, 1);
        m = $urandom_range(0, 2);
        s = $urandom_range(1, N - 2);
        q.delete();
        for (int j = 0; j < m; j++) q.push_back({3'($urandom_range(0, N - 1)), 32'($urandom)});
        clear_model_l();
        flush_req = 1'b1;
        if (c == 1) begin
          sw_tlbl_we = 1'b1; sw_tlbl_idx = P'($urandom_range(0, N - 1)); sw_tlbl_dat = $urandom;
          mod_l[sw_tlbl_idx] = sw_tlbl_dat;
        end
        #1;
        chk("rnd_f_we", 64'(tlbl_we), 64'd0);
        chk("rnd_f_h_we", 64'(tlbh_we), 64'd1);
        s0 = stall_n;
        d0 = done_n;
        cyc();
        idle_in();
        for (int t = 1; t <= 3 * N; t++) begin
          if (t >= s && q.size() > 0) begin
            sw_tlbl_we = 1'b1; sw_tlbl_idx = q[0][34:32]; sw_tlbl_dat = q[0][31:0];
          end
          #1;
          if (sw_tlbl_we && sw_tlbl_ready) begin
            wr = q.pop_front();
            mod_l[wr[34:32]] = wr[31:0];
          end
          cyc();
          idle_in();
        end
        #1;
        chk("rnd_f_pending", 64'(q.size()), 64'd0);
        chk("rnd_f_stall_cycles", 64'(stall_n - s0), 64'(N + ((c == 1 || m > 0) ? 1 : 0)));
        chk("rnd_f_done_pulses", 64'(done_n - d0), 64'd1);
        chk("rnd_f_busy", 64'(flush_busy), 64'd0);
        cyc();
      end
    end
    #1;
    cmp_arrays("rnd");
    cyc();

`ifdef ITLB_MAINT_PERF_EN
    rst = 1'b0;
    #1;
    chk("perf_rst", 64'(flush_cnt), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();
    repeat (3) begin
      flush_req = 1'b1;
      #1;
      cyc();
      sweep(-1, 1'b1);
    end
    #1;
    chk("perf_cnt", 64'(flush_cnt), 64'd3);
    cyc();
`endif

    // Asynchronous reset in the middle of a sweep
    flush_req = 1'b1;
    #1;
    cyc();
    idle_in();
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 64'(tlbl_we), 64'd0);
    chk("mid_rst_idx", 64'(tlbl_idx), 64'd0);
    chk("mid_rst_nxt", 64'(tlbl_nxt), 64'd0);
    chk("mid_rst_stall", 64'(fetch_stall), 64'd0);
    chk("mid_rst_busy", 64'(flush_busy), 64'd0);
    chk("mid_rst_done", 64'(flush_done), 64'd0);
    chk("mid_rst_ready", 64'(sw_tlbl_ready), 64'd1);
`ifdef ITLB_MAINT_PERF_EN
    chk("mid_rst_cnt", 64'(flush_cnt), 64'd0);
`endif
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    chk("post_rst_stall", 64'(fetch_stall), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/itlb_maint_ctrl.md
Name: itlb_maint_ctrl

Overview:
- Maintenance sequencer for the instruction TLB's lower/upper entry arrays.
- Shares the single write port of each array between MSR software writes (TLBL/TLBH) and a hardware invalidate-all sweep.
- Stalls fetch lookups while the sweep runs.
- Sits between the MSR write decode and the ITLB write ports; its outputs drive the ITLB `msr_imm_tlbl_*` / `msr_imm_tlbh_*` inputs directly.

Parameters:
- CONFIG_DW, 32, TLB entry width.
- CONFIG_ITLB_P_SETS, 7, log2 of ITLB set count; sweep length N = 2^CONFIG_ITLB_P_SETS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush_req  in  1  single-cycle request to invalidate all ITLB entries
- flush_busy  out  1  sweep in progress or pending
- flush_done  out  1  one-cycle pulse when a flush completes
- fetch_stall  out  1  fetch must hold ITLB re low
- sw_tlbl_we / sw_tlbl_idx / sw_tlbl_dat  in  1 / P_SETS / DW  software TLBL write
- sw_tlbl_ready  out  1  TLBL write accepted this cycle when high
- sw_tlbh_we / sw_tlbh_idx / sw_tlbh_dat  in  1 / P_SETS / DW  software TLBH write; always accepted
- tlbl_we / tlbl_idx / tlbl_nxt  out  1 / P_SETS / DW  to ITLB lower array
- tlbh_we / tlbh_idx / tlbh_nxt  out  1 / P_SETS / DW  to ITLB upper array

Behaviour:
- **Reset values:** state=IDLE, cnt=0, pend=0, buffer empty; every output is 0 except sw_tlbl_ready=1.
- **States:** IDLE, SWEEP, DRAIN. All outputs are combinational from state/regs/inputs; the array write lands at the clock edge of the cycle that asserts `*_we`.
- **IDLE:**
  - sw TLBL write passes through the same cycle (tlbl_we=1, idx/dat forwarded).
  - On flush_req → SWEEP, cnt=0.
  - If flush_req and sw_tlbl_we coincide, the write is ordered after the flush: it goes into the buffer and is not issued this cycle.
- **SWEEP:**
  - Each cycle: tlbl_we=1, tlbl_idx=cnt, tlbl_nxt=0 (clears V).
  - cnt increments, wrapping at N-1. Exactly N writes, indices 0..N-1 ascending.
  - After the write of index N-1: → DRAIN if the buffer is valid, else → IDLE with flush_done=1 in that transition cycle.
- **DRAIN:**
  - One cycle: issue the buffered TLBL write, clear the buffer, flush_done=1, → IDLE.
  - If pend=1, → SWEEP instead of IDLE; pend is cleared and flush_done is still pulsed.
- **TLBL buffer:**
  - One entry (idx+dat+valid).
  - sw_tlbl_ready = ~(state!=IDLE & buf_valid).
  - A write offered while ready is low is dropped; the master must hold it until ready.
  - A second write while the buffer is valid is not accepted.
- **TLBH:** software writes always pass straight through in every state (the sweep never uses the H port).
- **flush_req while busy:** sets pend; at sweep end the controller restarts the sweep (via DRAIN if the buffer is valid) and pulses flush_done once per completed sweep. Multiple requests while pend=1 collapse into one.
- **flush_busy:** = (state!=IDLE) | pend.
- **fetch_stall:** = state!=IDLE.
- **Reset mid-sweep:** abort immediately. Partial invalidation is acceptable; software re-flushes.

Optional Feature:
- Macro: ITLB_MAINT_PERF_EN.
- When defined: adds output flush_cnt [15:0]. It increments on every flush_done pulse, saturates at 0xFFFF, and resets to 0.
- When undefined: the port and counter are absent, with no other behavioural change.

Test Plan:
- P_SETS=3, flush_req at cycle 0 → tlbl_we=1 for cycles 1..8 with idx 0..7 and nxt=0; flush_done=1 at cycle 8; fetch_stall=1 in cycles 1..8.
- IDLE, sw_tlbl_we idx=5 dat=0xABCD0001 → tlbl_we=1, idx=5, nxt=0xABCD0001 the same cycle; sw_tlbl_ready stays 1.
- flush_req and sw_tlbl_we idx=2 in the same cycle → sweep writes 0..7, then DRAIN writes idx 2 with the data; flush_done in the DRAIN cycle; final array entry 2 non-zero.
- During SWEEP, two sw TLBL writes back-to-back → first accepted (buffered), ready drops to 0 for the second; the second is accepted after return to IDLE. A TLBH write mid-sweep appears on tlbh_we in the same cycle.
- flush_req at sweep cycle 4 → second full 8-write sweep follows immediately; two flush_done pulses; flush_busy high throughout.
- ITLB_MAINT_PERF_EN defined: 3 flushes → flush_cnt=3; async reset asserted mid-sweep → all outputs 0 immediately, flush_cnt=0.
